// File: rtl/bram_stream_ctrl.sv
// Burst controller in front of a true-dual-port BRAM: captures a stream burst
// through port A, then replays it through port B with latency-hiding credits.
module bram_stream_ctrl #(
  parameter int DATA_W       = 18,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic              bram_web,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_regceb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic [1:0]        state
);

  // Both streams: a beat transfers on a cycle where valid && ready are high at
  // the clock edge; valid never waits on ready, and a stalled output beat holds.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [1:0]              state_q;
  logic [ADDR_W:0]         len_q;
  logic [ADDR_W:0]         wr_cnt;
  logic [ADDR_W:0]         rd_cnt;
  logic [ADDR_W:0]         out_cnt;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]       buf_mem [BUF_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           buf_count;
  logic [CW-1:0]           in_flight;

  logic accept, wr_last, credit_ok, issue, push, buf_empty, pop;
  logic store, unload, head_last;
  logic [DATA_W-1:0] head;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CW'(vld_pipe[i]);
  end

  assign accept    = (state_q == S_WRITE) && s_valid;
  assign wr_last   = accept && (wr_cnt == len_q - 1'b1);
  // Credits count words in flight in the BRAM pipe plus words parked in the buffer.
  assign credit_ok = ({1'b0, in_flight} + {1'b0, buf_count}) < (CW + 1)'(BUF_DEPTH);
  assign issue     = (state_q == S_READ) && (rd_cnt < len_q) && credit_ok;
  assign push      = vld_pipe[READ_LATENCY-1];
  assign buf_empty = (buf_count == '0);
  // An empty buffer passes the arriving BRAM word straight through.
  assign head      = buf_empty ? bram_doutb : buf_mem[rd_ptr];
  assign head_last = (out_cnt == len_q - 1'b1);
  assign pop       = m_valid && m_ready;
  assign store     = push && !(buf_empty && pop);
  assign unload    = pop && !buf_empty;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign state       = state_q;
  assign s_ready     = (state_q == S_WRITE);
  assign m_valid     = !buf_empty || push;
  assign m_data      = m_valid ? head : '0;
  assign m_last      = m_valid && head_last;
  assign bram_ena    = accept;
  assign bram_wea    = accept;
  assign bram_addra  = accept ? wr_cnt[ADDR_W-1:0] : '0;
  assign bram_dina   = accept ? s_data : '0;
  assign bram_enb    = issue;
  assign bram_web    = 1'b0;
  assign bram_addrb  = issue ? rd_cnt[ADDR_W-1:0] : '0;
  assign bram_regceb = 1'b1;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
            len_q   <= (len > DEPTH_L) ? DEPTH_L : len;
            state_q <= (len == '0) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (accept) wr_cnt <= wr_cnt + 1'b1;
          if (wr_last) state_q <= S_READ;
        end
        S_READ: begin
          if (issue) rd_cnt <= rd_cnt + 1'b1;
          if (pop) out_cnt <= out_cnt + 1'b1;
          if (pop && head_last) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      vld_pipe  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      vld_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (store) begin
        buf_mem[wr_ptr] <= bram_doutb;
        wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (unload) rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({store, unload})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Bench for bram_stream_ctrl: two instances (HIGH_PERFORMANCE and LOW_LATENCY BRAM)
// driven in lockstep, each checked against a burst-level scoreboard.
module tb_bram_stream_ctrl;
  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int BUFD  = 4;

  logic clka = 1'b0;
  logic rsta, start, s_valid, m_ready;
  logic [AW:0]   len;
  logic [DW-1:0] s_data;

  logic          busy [2], done [2], s_ready [2], m_valid [2], m_last [2];
  logic [DW-1:0] m_data [2], dina [2], doutb [2];
  logic          ena [2], wea [2], enb [2], web [2], regceb [2];
  logic [AW-1:0] addra [2], addrb [2];
  logic [1:0]    state [2];

  always #5 clka = ~clka;

  bram_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2), .BUF_DEPTH(BUFD)) dut0 (
    .clka(clka), .rsta(rsta), .start(start), .len(len), .busy(busy[0]), .done(done[0]),
    .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]), .m_last(m_last[0]),
    .bram_ena(ena[0]), .bram_wea(wea[0]), .bram_addra(addra[0]), .bram_dina(dina[0]),
    .bram_enb(enb[0]), .bram_web(web[0]), .bram_addrb(addrb[0]), .bram_regceb(regceb[0]),
    .bram_doutb(doutb[0]), .state(state[0]));

  bram_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1), .BUF_DEPTH(BUFD)) dut1 (
    .clka(clka), .rsta(rsta), .start(start), .len(len), .busy(busy[1]), .done(done[1]),
    .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]), .m_last(m_last[1]),
    .bram_ena(ena[1]), .bram_wea(wea[1]), .bram_addra(addra[1]), .bram_dina(dina[1]),
    .bram_enb(enb[1]), .bram_web(web[1]), .bram_addrb(addrb[1]), .bram_regceb(regceb[1]),
    .bram_doutb(doutb[1]), .state(state[1]));

  // BRAM models: no-change read port, 2-stage (output register) and 1-stage.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] r0;
  always @(posedge clka) begin
    if (ena[0] && wea[0]) mem0[addra[0]] <= dina[0];
    if (enb[0]) r0 <= mem0[addrb[0]];
    if (regceb[0]) doutb[0] <= r0;
  end
  always @(posedge clka) begin
    if (ena[1] && wea[1]) mem1[addra[1]] <= dina[1];
    if (enb[1]) doutb[1] <= mem1[addrb[1]];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cur_len = 0;
  int mode = 0;
  logic [DW-1:0] exp_q[$];

  int wr_m [2], rd_m [2], out_idx [2], first_issue [2], first_valid [2];
  int last_pop [2], start_cyc [2], done_cnt [2];
  bit prev_stall [2], prev_last [2], prev_done [2];
  logic [DW-1:0] prev_data [2];
  bit acc;

  function automatic int rl(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int eff_len();
    return (cur_len > DEPTH) ? DEPTH : cur_len;
  endfunction

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed 0x%0h expected 0x%0h", tag, k, obs, expv);
    end
  endtask

  task automatic clear_mon(int k);
    wr_m[k] = 0; rd_m[k] = 0; out_idx[k] = 0;
    first_issue[k] = -1; first_valid[k] = -1; last_pop[k] = -1;
    start_cyc[k] = cyc; prev_stall[k] = 0; prev_done[k] = 0;
  endtask

  // Per-cycle scoreboard, sampled on the falling edge.
  task automatic sample();
    int e;
    e = eff_len();
    acc = s_valid && s_ready[0];
    for (int k = 0; k < 2; k++) begin
      if (rsta) begin
        clear_mon(k);
        continue;
      end
      if (start && !busy[k]) clear_mon(k);
      if (prev_done[k]) check("busy_after_done", k, busy[k], 0);
      prev_done[k] = done[k];
      check("ab_exclusive", k, ena[k] && enb[k], 0);
      check("web_tied", k, web[k], 0);
      check("regceb_tied", k, regceb[k], 1);
      if (busy[k]) check("s_ready", k, s_ready[k], wr_m[k] < e);
      check("ena_handshake", k, ena[k], s_valid && s_ready[k]);
      if (ena[k]) begin
        check("wea", k, wea[k], 1);
        check("addra", k, addra[k], wr_m[k]);
        check("write_in_range", k, wr_m[k] < e, 1);
        if (wr_m[k] < e) check("dina", k, dina[k], exp_q[wr_m[k]]);
        wr_m[k]++;
      end
      if (enb[k]) begin
        check("addrb", k, addrb[k], rd_m[k]);
        check("read_in_range", k, rd_m[k] < e, 1);
        if (rd_m[k] == 0) first_issue[k] = cyc;
        rd_m[k]++;
        check("occupancy", k, (rd_m[k] - out_idx[k]) <= BUFD, 1);
      end
      if (prev_stall[k]) begin
        check("stall_valid", k, m_valid[k], 1);
        check("stall_data", k, m_data[k], prev_data[k]);
        check("stall_last", k, m_last[k], prev_last[k]);
      end
      if (m_valid[k]) begin
        check("no_extra_word", k, out_idx[k] < e, 1);
        if (first_valid[k] < 0) begin
          first_valid[k] = cyc;
          check("first_latency", k, cyc - first_issue[k], rl(k));
        end
        if (out_idx[k] < e) begin
          check("m_data", k, m_data[k], exp_q[out_idx[k]]);
          check("m_last", k, m_last[k], out_idx[k] == e - 1);
        end
        if (m_ready) begin
          out_idx[k]++;
          last_pop[k] = cyc;
        end
      end
      prev_stall[k] = m_valid[k] && !m_ready;
      prev_data[k]  = m_data[k];
      prev_last[k]  = m_last[k];
      if (done[k]) begin
        done_cnt[k]++;
        check("done_words", k, out_idx[k], e);
        if (e == 0) check("done_timing", k, cyc - start_cyc[k], 1);
        else        check("done_timing", k, cyc - last_pop[k], 1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clka);
    sample();
    @(posedge clka);
    #1;
    cyc++;
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic fill(int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(DW'($urandom));
  endtask

  task automatic start_burst(int l);
    cur_len = l;
    len = (AW + 1)'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(int gap, bit inject);
    int j, g;
    j = 0; g = 0;
    while (j < eff_len() && g < 5000) begin
      s_valid = ($urandom_range(99) >= gap);
      s_data  = s_valid ? exp_q[j] : DW'($urandom);
      start   = inject && (j == 5);
      if (start) len = 11'd3;
      tick();
      if (acc) j++;
      g++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    check("write_complete", 0, j, eff_len());
  endtask

  task automatic wait_done(int budget, bit inject);
    int t0, t1, g;
    t0 = done_cnt[0] + 1; t1 = done_cnt[1] + 1; g = 0;
    while ((done_cnt[0] < t0 || done_cnt[1] < t1) && g < budget) begin
      start = inject && (g == 2);
      if (start) len = 11'd7;
      tick();
      g++;
    end
    start = 1'b0;
    check("done_seen", 0, done_cnt[0], t0);
    check("done_seen", 1, done_cnt[1], t1);
    tick();
    for (int k = 0; k < 2; k++) check("burst_words", k, out_idx[k], eff_len());
  endtask

  task automatic check_throughput();
    for (int k = 0; k < 2; k++)
      check("throughput", k, last_pop[k] - first_valid[k], eff_len() - 1);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, busy[k], 0);       check("rst_done", k, done[k], 0);
      check("rst_s_ready", k, s_ready[k], 0); check("rst_m_valid", k, m_valid[k], 0);
      check("rst_m_data", k, m_data[k], 0);   check("rst_m_last", k, m_last[k], 0);
      check("rst_ena", k, ena[k], 0);         check("rst_wea", k, wea[k], 0);
      check("rst_addra", k, addra[k], 0);     check("rst_dina", k, dina[k], 0);
      check("rst_enb", k, enb[k], 0);         check("rst_web", k, web[k], 0);
      check("rst_addrb", k, addrb[k], 0);     check("rst_regceb", k, regceb[k], 1);
      check("rst_state", k, state[k], 0);
    end
  endtask

  initial begin
    int d0, d1, g;
    rsta = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      clear_mon(k);
    end
    repeat (3) @(posedge clka);
    #1;
    check_reset_outputs();
    rsta = 1'b0;
    tick();

    // Basic burst
    mode = 0;
    exp_q.delete();
    exp_q.push_back(18'h11); exp_q.push_back(18'h22);
    exp_q.push_back(18'h33); exp_q.push_back(18'h44);
    start_burst(4);
    send_words(0, 0);
    wait_done(200, 0);
    check_throughput();

    // Backpressure 1-0-0-1
    mode = 1;
    fill(8);
    start_burst(8);
    send_words(0, 0);
    wait_done(300, 0);

    // Zero-length burst
    mode = 0;
    exp_q.delete();
    start_burst(0);
    wait_done(10, 0);

    // Full-depth burst
    mode = 0;
    fill(DEPTH);
    start_burst(DEPTH);
    send_words(0, 0);
    wait_done(3000, 0);
    check_throughput();

    // Input gaps with ignored start pulses, random backpressure
    mode = 2;
    fill(16);
    start_burst(16);
    send_words(50, 1);
    wait_done(500, 1);

    // Reset in the middle of the read phase
    mode = 0;
    fill(8);
    start_burst(8);
    send_words(0, 0);
    g = 0;
    while (out_idx[0] < 3 && g < 100) begin
      tick();
      g++;
    end
    check("reach_3_outputs", 0, out_idx[0] >= 3, 1);
    d0 = done_cnt[0]; d1 = done_cnt[1];
    rsta = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    tick();
    rsta = 1'b0;
    tick();
    tick();
    check("no_done_after_abort", 0, done_cnt[0], d0);
    check("no_done_after_abort", 1, done_cnt[1], d1);
    check("idle_after_abort", 0, busy[0], 0);
    check("idle_after_abort", 1, busy[1], 0);

    // Fresh bursts after the abort
    mode = 2;
    fill(5);
    start_burst(5);
    send_words(30, 0);
    wait_done(300, 0);
    mode = 1;
    fill(1);
    start_burst(1);
    send_words(0, 0);
    wait_done(100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
